// File: rtl/view_project_pkg.sv
// view_project_pkg: shared definitions for the screen-projection block.
//   - 10-10-8 packed vector layout {x[27:18], y[17:8], z[7:0]}, two's complement
//   - 13-bit screen location layout {loc_y[12:7], loc_x[6:0]}
//   - iterative divider width and FSM state encoding
//   - helpers to unpack a vector to 32-bit signed lanes and take a magnitude
package view_project_pkg;

    localparam int VEC_W     = 28;
    localparam int X_W       = 10;
    localparam int Y_W       = 10;
    localparam int Z_W       = 8;
    localparam int X_LSB     = 18;
    localparam int Y_LSB     = 8;
    localparam int Z_LSB     = 0;
    localparam int DIST_W    = 10;

    localparam int LOC_X_W   = 7;
    localparam int LOC_Y_W   = 6;
    localparam int LOC_W     = LOC_X_W + LOC_Y_W;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = 6;

    localparam logic signed [DIV_W-1:0] LOC_X_MAX = 32'sd127;
    localparam logic signed [DIV_W-1:0] LOC_Y_MAX = 32'sd63;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAC  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FMT  = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    typedef struct packed {
        logic signed [DIV_W-1:0] x;
        logic signed [DIV_W-1:0] y;
        logic signed [DIV_W-1:0] z;
    } vec32_t;

    // Sign-extend each field of a packed 10-10-8 vector to 32 bits.
    function automatic vec32_t unpack_vec(input logic [VEC_W-1:0] v);
        vec32_t r;
        r.x = {{(DIV_W-X_W){v[X_LSB+X_W-1]}}, v[X_LSB+X_W-1:X_LSB]};
        r.y = {{(DIV_W-Y_W){v[Y_LSB+Y_W-1]}}, v[Y_LSB+Y_W-1:Y_LSB]};
        r.z = {{(DIV_W-Z_W){v[Z_LSB+Z_W-1]}}, v[Z_LSB+Z_W-1:Z_LSB]};
        return r;
    endfunction

    // Magnitude of a 32-bit two's complement value (inputs never reach -2^31).
    function automatic logic [DIV_W-1:0] mag32(input logic signed [DIV_W-1:0] v);
        logic [DIV_W-1:0] u;
        u = v;
        return u[DIV_W-1] ? (~u + 32'd1) : u;
    endfunction

endpackage

// File: rtl/view_div_iter.sv
// view_div_iter: 32-cycle restoring unsigned divider.
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle pulse; dividend/divisor are sampled and the first
//                quotient bit is produced on the same edge
//   dividend   : unsigned numerator
//   divisor    : unsigned denominator (caller guarantees non-zero)
//   done       : high from the 32nd iteration until the next start
//   quotient   : truncated quotient, valid while done is high
module view_div_iter
    import view_project_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    logic [DIV_W-1:0]     rem_r;
    logic [DIV_W-1:0]     quo_r;
    logic [DIV_W-1:0]     dvs_r;
    logic [DIV_CNT_W-1:0] cnt_r;
    logic                 busy_r;
    logic                 done_r;

    logic [DIV_W-1:0]     rem_in_s;
    logic [DIV_W-1:0]     quo_in_s;
    logic [DIV_W-1:0]     dvs_in_s;
    logic [DIV_W:0]       shifted_s;
    logic [DIV_W-1:0]     rem_nx_s;
    logic [DIV_W-1:0]     quo_nx_s;

    // Operand select: a start seeds the first step directly from the inputs.
    always_comb begin
        rem_in_s = rem_r;
        quo_in_s = quo_r;
        dvs_in_s = dvs_r;
        if (start) begin
            rem_in_s = {DIV_W{1'b0}};
            quo_in_s = dividend;
            dvs_in_s = divisor;
        end else begin
            rem_in_s = rem_r;
            quo_in_s = quo_r;
            dvs_in_s = dvs_r;
        end
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted_s = {rem_in_s, quo_in_s[DIV_W-1]};
        rem_nx_s  = shifted_s[DIV_W-1:0];
        quo_nx_s  = {quo_in_s[DIV_W-2:0], 1'b0};
        if (shifted_s >= {1'b0, dvs_in_s}) begin
            rem_nx_s = DIV_W'(shifted_s - {1'b0, dvs_in_s});
            quo_nx_s = {quo_in_s[DIV_W-2:0], 1'b1};
        end else begin
            rem_nx_s = shifted_s[DIV_W-1:0];
            quo_nx_s = {quo_in_s[DIV_W-2:0], 1'b0};
        end
    end

    // Iteration state: 1 step on start plus 31 further steps while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r  <= {DIV_W{1'b0}};
            quo_r  <= {DIV_W{1'b0}};
            dvs_r  <= {DIV_W{1'b0}};
            cnt_r  <= {DIV_CNT_W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            rem_r  <= rem_nx_s;
            quo_r  <= quo_nx_s;
            dvs_r  <= divisor;
            cnt_r  <= DIV_CNT_W'(1);
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            rem_r <= rem_nx_s;
            quo_r <= quo_nx_s;
            cnt_r <= cnt_r + DIV_CNT_W'(1);
            if (cnt_r == DIV_CNT_W'(DIV_W-1)) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end
        end
    end

    assign done     = done_r;
    assign quotient = quo_r;

endmodule

// File: rtl/view_project.sv
// view_project: maps a camera-space point back to a screen location.
//   clk, rst     : clock, synchronous active-high reset (aborts any request)
//   in_valid     : request valid; accepted only while in_ready is high
//   in_ready     : high only when idle
//   point        : {px,py,pz} 10-10-8 two's complement
//   view_normal  : {dx,dy,dz} 10-10-8 two's complement
//   view_dist    : d0, unsigned
//   out_valid    : result valid, held until out_ready
//   out_ready    : consumer accepts the result
//   view_loc     : {loc_y[5:0], loc_x[6:0]}
//   out_hit      : point in front of the camera and on-screen
// Fixed latency of 34 cycles from the accept edge to out_valid.
// Build option VIEW_PROJECT_CLIP_EN: off-screen coordinates saturate to the
// screen edge instead of wrapping to their low bits.
module view_project
    import view_project_pkg::*;
#(
    parameter int SY_SHIFT  = 8,
    parameter int LOC_X_OFF = 63,
    parameter int LOC_Y_OFF = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VEC_W-1:0]  point,
    input  logic [VEC_W-1:0]  view_normal,
    input  logic [DIST_W-1:0] view_dist,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOC_W-1:0]  view_loc,
    output logic              out_hit
);

    state_t state_r, state_n_s;

    logic [VEC_W-1:0]  point_r;
    logic [VEC_W-1:0]  normal_r;
    logic [DIST_W-1:0] dist_r;
    logic              a_pos_r;
    logic              nx_neg_r;
    logic              ny_neg_r;

    logic              in_ready_r;
    logic              out_valid_r;
    logic [LOC_W-1:0]  view_loc_r;
    logic              out_hit_r;

    logic              capture_s;
    logic              div_start_s;
    logic              fmt_s;
    logic              release_s;

    vec32_t                  p_s, d_s;
    logic signed [DIV_W-1:0] d0_s, a_s, b_s, nx_s, ny_s;
    logic                    a_pos_s;
    logic [DIV_W-1:0]        divisor_s;

    logic                    done_x_s, done_y_s;
    logic [DIV_W-1:0]        q_x_s, q_y_s;

    logic signed [DIV_W-1:0] sx_s, sy_s, loc_x32_s, loc_y32_s;
    logic                    x_on_s, y_on_s;
    logic [LOC_X_W-1:0]      loc_x_s;
    logic [LOC_Y_W-1:0]      loc_y_s;
    logic [LOC_W-1:0]        loc_s;
    logic                    hit_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: state_n_s = in_valid ? ST_MAC : ST_IDLE;
            ST_MAC:  state_n_s = ST_DIV;
            ST_DIV:  state_n_s = (done_x_s && done_y_s) ? ST_FMT : ST_DIV;
            ST_FMT:  state_n_s = ST_HOLD;
            ST_HOLD: state_n_s = out_ready ? ST_IDLE : ST_HOLD;
            default: state_n_s = ST_IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        capture_s   = 1'b0;
        div_start_s = 1'b0;
        fmt_s       = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            ST_IDLE: capture_s   = in_valid;
            ST_MAC:  div_start_s = 1'b1;
            ST_DIV:  div_start_s = 1'b0;
            ST_FMT:  fmt_s       = 1'b1;
            ST_HOLD: release_s   = out_ready;
            default: capture_s   = 1'b0;
        endcase
    end

    // Products for the MAC cycle; everything held at 32 bits signed.
    always_comb begin
        p_s       = unpack_vec(point_r);
        d_s       = unpack_vec(normal_r);
        d0_s      = {{(DIV_W-DIST_W){1'b0}}, dist_r};
        a_s       = p_s.x * d_s.x + p_s.y * d_s.y + p_s.z * d_s.z;
        b_s       = p_s.x * d_s.y - p_s.y * d_s.x;
        nx_s      = d0_s * b_s;
        ny_s      = d0_s * (p_s.z <<< SY_SHIFT);
        a_pos_s   = (a_s > 32'sd0);
        // A point behind or beside the camera still runs the dividers so the
        // latency stays fixed; dividing by 1 keeps them well-defined.
        divisor_s = a_pos_s ? a_s : 32'd1;
    end

    // Request capture and sign bookkeeping for the divider results.
    always_ff @(posedge clk) begin
        if (rst) begin
            point_r  <= {VEC_W{1'b0}};
            normal_r <= {VEC_W{1'b0}};
            dist_r   <= {DIST_W{1'b0}};
            a_pos_r  <= 1'b0;
            nx_neg_r <= 1'b0;
            ny_neg_r <= 1'b0;
        end else if (capture_s) begin
            point_r  <= point;
            normal_r <= view_normal;
            dist_r   <= view_dist;
        end else if (div_start_s) begin
            a_pos_r  <= a_pos_s;
            nx_neg_r <= nx_s[DIV_W-1];
            ny_neg_r <= ny_s[DIV_W-1];
        end
    end

    view_div_iter u_div_x (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .dividend (mag32(nx_s)),
        .divisor  (divisor_s),
        .done     (done_x_s),
        .quotient (q_x_s)
    );

    view_div_iter u_div_y (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .dividend (mag32(ny_s)),
        .divisor  (divisor_s),
        .done     (done_y_s),
        .quotient (q_y_s)
    );

    // Restore quotient signs, offset to screen space and range-check.
    always_comb begin
        sx_s      = nx_neg_r ? (32'sd0 - $signed(q_x_s)) : $signed(q_x_s);
        sy_s      = ny_neg_r ? (32'sd0 - $signed(q_y_s)) : $signed(q_y_s);
        loc_x32_s = sx_s + LOC_X_OFF;
        loc_y32_s = sy_s + LOC_Y_OFF;
        x_on_s    = (loc_x32_s >= 32'sd0) && (loc_x32_s <= LOC_X_MAX);
        y_on_s    = (loc_y32_s >= 32'sd0) && (loc_y32_s <= LOC_Y_MAX);
`ifdef VIEW_PROJECT_CLIP_EN
        if (loc_x32_s < 32'sd0) begin
            loc_x_s = {LOC_X_W{1'b0}};
        end else if (loc_x32_s > LOC_X_MAX) begin
            loc_x_s = {LOC_X_W{1'b1}};
        end else begin
            loc_x_s = loc_x32_s[LOC_X_W-1:0];
        end
        if (loc_y32_s < 32'sd0) begin
            loc_y_s = {LOC_Y_W{1'b0}};
        end else if (loc_y32_s > LOC_Y_MAX) begin
            loc_y_s = {LOC_Y_W{1'b1}};
        end else begin
            loc_y_s = loc_y32_s[LOC_Y_W-1:0];
        end
`else
        loc_x_s = loc_x32_s[LOC_X_W-1:0];
        loc_y_s = loc_y32_s[LOC_Y_W-1:0];
`endif
        if (a_pos_r) begin
            loc_s = {loc_y_s, loc_x_s};
        end else begin
            loc_s = {LOC_Y_W'(LOC_Y_OFF), LOC_X_W'(LOC_X_OFF)};
        end
        hit_s = a_pos_r && x_on_s && y_on_s;
    end

    // Registered outputs; the result is held until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            view_loc_r  <= {LOC_W{1'b0}};
            out_hit_r   <= 1'b0;
        end else begin
            in_ready_r <= (state_n_s == ST_IDLE);
            if (fmt_s) begin
                out_valid_r <= 1'b1;
                view_loc_r  <= loc_s;
                out_hit_r   <= hit_s;
            end else if (release_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign view_loc  = view_loc_r;
    assign out_hit   = out_hit_r;

endmodule

// File: tb/tb_view_project.sv
// tb_view_project: scoreboard bench for view_project. Expected {hit, loc}
// words are computed by a reference model when a request is driven and
// compared when the result appears.
module tb_view_project;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] point;
    logic [27:0] view_normal;
    logic [9:0]  view_dist;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] view_loc;
    logic        out_hit;

    int          num_checks = 0;
    int          num_errors = 0;
    logic [13:0] exp_q[$];

    always #5 clk = ~clk;

    view_project dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .point       (point),
        .view_normal (view_normal),
        .view_dist   (view_dist),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .view_loc    (view_loc),
        .out_hit     (out_hit)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] pack_vec(input int x, input int y, input int z);
        logic [31:0] ux, uy, uz;
        ux = x; uy = y; uz = z;
        return {ux[9:0], uy[9:0], uz[7:0]};
    endfunction

    // Reference model: returns {hit, loc_y[5:0], loc_x[6:0]}.
    function automatic logic [13:0] model(input int px, input int py, input int pz,
                                          input int dx, input int dy, input int dz,
                                          input int d0);
        longint a, b, nx, ny, lx, ly;
        logic [63:0] ulx, uly;
        logic hit;
        logic [6:0] locx;
        logic [5:0] locy;
        a  = longint'(px) * dx + longint'(py) * dy + longint'(pz) * dz;
        b  = longint'(px) * dy - longint'(py) * dx;
        nx = longint'(d0) * b;
        ny = longint'(d0) * (longint'(pz) * 256);
        if (a <= 0) return {1'b0, 6'd31, 7'd63};
        lx  = nx / a + 63;
        ly  = ny / a + 31;
        ulx = lx;
        uly = ly;
        hit = (lx >= 0) && (lx <= 127) && (ly >= 0) && (ly <= 63);
`ifdef VIEW_PROJECT_CLIP_EN
        locx = (lx < 0) ? 7'd0 : (lx > 127) ? 7'd127 : ulx[6:0];
        locy = (ly < 0) ? 6'd0 : (ly > 63)  ? 6'd63  : uly[5:0];
`else
        locx = ulx[6:0];
        locy = uly[5:0];
`endif
        return {hit, locy, locx};
    endfunction

    // Drive one request, check latency and result, hold for hold_cycles.
    task automatic run_req(input string tag, input int px, input int py, input int pz,
                           input int dx, input int dy, input int dz, input int d0,
                           input int hold_cycles);
        int lat;
        int spurious;
        logic [13:0] exp;
        exp_q.push_back(model(px, py, pz, dx, dy, dz, d0));
        check_eq({tag, "_in_ready"}, in_ready, 1);
        point       = pack_vec(px, py, pz);
        view_normal = pack_vec(dx, dy, dz);
        view_dist   = d0[9:0];
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        point    = 28'd0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, lat, 34);
        exp = exp_q.pop_front();
        check_eq({tag, "_loc_x"}, view_loc[6:0], exp[6:0]);
        check_eq({tag, "_loc_y"}, view_loc[12:7], exp[12:7]);
        check_eq({tag, "_hit"}, out_hit, exp[13]);
        for (int i = 0; i < hold_cycles; i++) begin
            point    = pack_vec(-100, 50, 3);
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            check_eq({tag, "_hold_loc"}, view_loc, exp[12:0]);
            check_eq({tag, "_hold_valid"}, out_valid, 1);
            check_eq({tag, "_hold_in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_release_valid"}, out_valid, 0);
        check_eq({tag, "_release_in_ready"}, in_ready, 1);
        if (hold_cycles > 0) begin
            spurious = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (out_valid) spurious++;
            end
            check_eq({tag, "_no_spurious"}, spurious, 0);
        end
    endtask

    initial begin
        int rx, ry, rz, rdx, rdy, rdz, rd0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        point       = 28'd0;
        view_normal = 28'd0;
        view_dist   = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_view_loc", view_loc, 0);
        check_eq("rst_out_hit", out_hit, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_req("center",   256,    0,  0, 256, 0, 0, 128, 0);
        run_req("sx32",     256,  -64,  0, 256, 0, 0, 128, 0);
        run_req("sy8",      256,    0, 16, 256, 0, 0, 128, 0);
        run_req("behind",  -256,    0,  0, 256, 0, 0, 128, 0);
        run_req("zero",       0,    0,  0, 256, 0, 0, 128, 0);
        run_req("offscr",   256, -256,  0, 256, 0, 0, 128, 0);
        run_req("hold",     256,  -64,  0, 256, 0, 0, 128, 10);

        // Abort a request in its 15th divide cycle.
        point       = pack_vec(256, -64, 16);
        view_normal = pack_vec(256, 0, 0);
        view_dist   = 10'd128;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_in_ready", in_ready, 1);
        run_req("after_abort", 256, 0, 16, 256, 0, 0, 128, 0);

        for (int k = 0; k < 8; k++) begin
            rx  = int'($urandom_range(1023, 0)) - 512;
            ry  = int'($urandom_range(1023, 0)) - 512;
            rz  = int'($urandom_range(255, 0)) - 128;
            rdx = int'($urandom_range(1023, 0)) - 512;
            rdy = int'($urandom_range(1023, 0)) - 512;
            rdz = int'($urandom_range(255, 0)) - 128;
            rd0 = int'($urandom_range(1023, 0));
            run_req("rand", rx, ry, rz, rdx, rdy, rdz, rd0, 0);
        end
        run_req("near_edge", 256, 120, -2, 256, 8, 4, 200, 0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
